reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_pkg.sv | 22 ++
 rtl/reg_wb_slot.sv | 76 +++++++
 rtl/reg_wb_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: constants and helpers shared by the writeback arbiter files.
//   REG_W    : register index width
//   DATA_W   : writeback data width
//   XZR_IDX  : zero register; writes to it are dropped at the RF port
//   port_e   : requester identity, also used for the round-robin pointer
//   reg_mask : one-hot mask of a register index (zero for XZR or when invalid)
package reg_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;
    localparam logic [REG_W-1:0] XZR_IDX = 5'd31;

    typedef enum logic {
        PORT_ALU = 1'b0,
        PORT_MEM = 1'b1
    } port_e;

    function automatic logic [31:0] reg_mask(input logic [REG_W-1:0] r, input logic vld);
        reg_mask = (vld && (r != XZR_IDX)) ? (32'd1 << r) : 32'd0;
    endfunction

endpackage

// File: rtl/reg_wb_slot.sv
// reg_wb_slot: single-entry valid/ready holding register for one requester.
//   clk, rst_n     : clock, synchronous active-low reset
//   in_valid_i     : requester has a write to hand over
//   in_reg_i/data_i: destination register and data of that write
//   in_young_i     : age bit to store on load (1 = the other slot holds an older entry)
//   age_clr_i      : other slot no longer holds an older entry; clear the age bit
//   grant_i        : arbiter grants this slot this cycle
//   in_ready_o     : slot can accept (empty, or draining on this edge)
//   valid_o, reg_o, data_o, young_o : stored entry
module reg_wb_slot
    import reg_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [REG_W-1:0]  in_reg_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_young_i,
    input  logic              age_clr_i,
    input  logic              grant_i,
    output logic              in_ready_o,
    output logic              valid_o,
    output logic [REG_W-1:0]  reg_o,
    output logic [DATA_W-1:0] data_o,
    output logic              young_o
);

    logic              valid_q, valid_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              young_q, young_d;
    logic              accept;

    assign in_ready_o = !valid_q || grant_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        reg_d   = reg_q;
        data_d  = data_q;
        young_d = young_q;
        if (accept) begin
            valid_d = 1'b1;
            reg_d   = in_reg_i;
            data_d  = in_data_i;
            young_d = in_young_i;
        end else begin
            if (grant_i) begin
                valid_d = 1'b0;
            end
            if (age_clr_i) begin
                young_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            young_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            young_q <= young_d;
        end
    end

    assign valid_o = valid_q;
    assign reg_o   = reg_q;
    assign data_o  = data_q;
    assign young_o = young_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges ALU and load writebacks onto one register-file write port.
//   clk, rst_n                        : clock, synchronous active-low reset
//   alu_valid/alu_reg/alu_data/alu_ready : ALU writeback handshake
//   mem_valid/mem_reg/mem_data/mem_ready : load writeback handshake
//   REG_WRITE, write_reg, writeData   : registered register-file write port
//   pending                           : per-register mask of accepted, unretired writes
// Build option: REG_WB_SCOREBOARD_EN enables the pending scoreboard; otherwise
// pending is tied to zero.
module reg_wb_arbiter
    import reg_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [REG_W-1:0]  mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              REG_WRITE,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] writeData,
    output logic [31:0]       pending
);

    logic              alu_vb, mem_vb;
    logic [REG_W-1:0]  alu_rb, mem_rb;
    logic [DATA_W-1:0] alu_db, mem_db;
    logic              alu_young, mem_young;
    logic              grant_alu, grant_mem;
    logic              alu_stays, mem_stays;

    port_e             last_q, last_d;
    logic              out_valid_q, out_valid_d;
    logic [REG_W-1:0]  out_reg_q, out_reg_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    // An entry is "young" if it was loaded while the other slot kept an older
    // entry; once that older entry leaves (or is replaced) the age bit clears.
    assign alu_stays = alu_vb && !grant_alu;
    assign mem_stays = mem_vb && !grant_mem;

    reg_wb_slot u_alu_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (alu_valid),
        .in_reg_i   (alu_reg),
        .in_data_i  (alu_data),
        .in_young_i (mem_stays),
        .age_clr_i  (!mem_stays),
        .grant_i    (grant_alu),
        .in_ready_o (alu_ready),
        .valid_o    (alu_vb),
        .reg_o      (alu_rb),
        .data_o     (alu_db),
        .young_o    (alu_young)
    );

    reg_wb_slot u_mem_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (mem_valid),
        .in_reg_i   (mem_reg),
        .in_data_i  (mem_data),
        .in_young_i (alu_stays),
        .age_clr_i  (!alu_stays),
        .grant_i    (grant_mem),
        .in_ready_o (mem_ready),
        .valid_o    (mem_vb),
        .reg_o      (mem_rb),
        .data_o     (mem_db),
        .young_o    (mem_young)
    );

    // Same destination: oldest first, simultaneous arrivals go MEM first.
    // Different destinations: round-robin against the last granted port.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_vb && mem_vb) begin
            if (alu_rb == mem_rb) begin
                grant_alu = mem_young && !alu_young;
                grant_mem = !grant_alu;
            end else if (last_q == PORT_ALU) begin
                grant_mem = 1'b1;
            end else begin
                grant_alu = 1'b1;
            end
        end else if (alu_vb) begin
            grant_alu = 1'b1;
        end else if (mem_vb) begin
            grant_mem = 1'b1;
        end
    end

    always_comb begin
        last_d      = last_q;
        out_valid_d = grant_alu || grant_mem;
        out_reg_d   = out_reg_q;
        out_data_d  = out_data_q;
        if (grant_alu) begin
            last_d     = PORT_ALU;
            out_reg_d  = alu_rb;
            out_data_d = alu_db;
        end else if (grant_mem) begin
            last_d     = PORT_MEM;
            out_reg_d  = mem_rb;
            out_data_d = mem_db;
        end
    end

    // Pointer resets to MEM so the first contended grant goes to ALU.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= PORT_MEM;
            out_valid_q <= 1'b0;
            out_reg_q   <= '0;
            out_data_q  <= '0;
        end else begin
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_reg_q   <= out_reg_d;
            out_data_q  <= out_data_d;
        end
    end

    // XZR entries still flow through the output stage but never write the RF.
    assign REG_WRITE = out_valid_q && (out_reg_q != XZR_IDX);
    assign write_reg = out_reg_q;
    assign writeData = out_data_q;

`ifdef REG_WB_SCOREBOARD_EN
    assign pending = reg_mask(alu_rb, alu_vb)
                   | reg_mask(mem_rb, mem_vb)
                   | reg_mask(out_reg_q, out_valid_q);
`else
    assign pending = 32'b0;
`endif

endmodule
